// File: rtl/adc_imi_pkg.sv
// Shared definitions for the multi-channel ADC emulator: mode codes, FSM states, LFSR constants.
// The LFSR pattern is only built when ADC_IMI_LFSR_EN is defined.
package adc_imi_pkg;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CHID  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Right-shifting Galois step: the bit shifted out selects the feedback mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/adc_imi_pattern.sv
// Pattern source: per-channel ramp counters, optional shared LFSR and the mode mux.
// Defining ADC_IMI_LFSR_EN adds the LFSR; otherwise mode 2 falls back to the ramp.
module adc_imi_pattern
    import adc_imi_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] fixed_val_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              adv_i,
    input  logic [1:0]        adv_mode_i,
    output logic [DATA_W-1:0] sample_o
);

    logic [DATA_W-1:0] ramp_q [N_CH];
    logic              ramp_adv;

`ifdef ADC_IMI_LFSR_EN
    logic [15:0] lfsr_q;

    assign ramp_adv = adv_i && (adv_mode_i == MODE_RAMP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv_i && (adv_mode_i == MODE_LFSR)) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end
`else
    assign ramp_adv = adv_i && ((adv_mode_i == MODE_RAMP) || (adv_mode_i == MODE_LFSR));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                ramp_q[i] <= '0;
            end
        end else if (ramp_adv) begin
            ramp_q[ch_i] <= ramp_q[ch_i] + DATA_W'(1);
        end
    end

    always_comb begin
        sample_o = ramp_q[ch_i];
        case (mode_i)
            MODE_FIXED: sample_o = fixed_val_i;
            MODE_CHID:  sample_o = DATA_W'(ch_i);
`ifdef ADC_IMI_LFSR_EN
            MODE_LFSR:  sample_o = lfsr_q[DATA_W-1:0];
`endif
            default:    sample_o = ramp_q[ch_i];
        endcase
    end

endmodule

// File: rtl/adc_imi_multi.sv
// Multi-channel SPI ADC emulator: each frame is LOAD, SHIFT (MSB-first serial out), GAP.
// Mode 2 uses an LFSR only when ADC_IMI_LFSR_EN is defined, otherwise it acts as the ramp.
module adc_imi_multi
    import adc_imi_pkg::*;
#(
    parameter int  DATA_W  = 12,
    parameter int  N_CH    = 4,
    parameter int  CLK_DIV = 2,
    parameter int  GAP     = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fixed_val,
    output logic              sck,
    output logic              cs_n,
    output logic              sdo,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   ch_out,
    output logic              data_valid,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [1:0]        mode_q, mode_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   ch_out_q, ch_out_d;
    logic              dv_q, dv_d;
    logic              pat_adv;
    logic [DATA_W-1:0] pat_sample;

    adc_imi_pattern #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .CH_W   (CH_W)
    ) u_pattern (
        .clk_i       (clk_25),
        .rst_i       (reset),
        .mode_i      (mode),
        .fixed_val_i (fixed_val),
        .ch_i        (ch_q),
        .adv_i       (pat_adv),
        .adv_mode_i  (mode_q),
        .sample_o    (pat_sample)
    );

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            half_q     <= '0;
            gap_q      <= '0;
            shreg_q    <= '0;
            sample_q   <= '0;
            data_out_q <= '0;
            mode_q     <= MODE_RAMP;
            ch_q       <= '0;
            ch_out_q   <= '0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            gap_q      <= gap_d;
            shreg_q    <= shreg_d;
            sample_q   <= sample_d;
            data_out_q <= data_out_d;
            mode_q     <= mode_d;
            ch_q       <= ch_d;
            ch_out_q   <= ch_out_d;
            dv_q       <= dv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        gap_d      = gap_q;
        shreg_d    = shreg_q;
        sample_d   = sample_q;
        data_out_d = data_out_q;
        mode_d     = mode_q;
        ch_d       = ch_q;
        ch_out_d   = ch_out_q;
        dv_d       = 1'b0;
        pat_adv    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d  = pat_sample;
                sample_d = pat_sample;
                mode_d   = mode;
                div_d    = '0;
                half_d   = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    half_d = half_q + HALF_W'(1);
                    // An odd half-period ends on a falling sck edge: present the next bit.
                    if (half_q[0]) shreg_d = shreg_q << 1;
                    if (half_q == HALF_W'(2 * DATA_W - 1)) begin
                        state_d    = ST_GAP;
                        gap_d      = '0;
                        dv_d       = 1'b1;
                        data_out_d = sample_q;
                        ch_out_d   = ch_q;
                        pat_adv    = 1'b1;
                        ch_d       = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = start ? ST_LOAD : ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial pins decode straight from registered state so reset clears them immediately.
    always_comb begin
        sck  = (state_q == ST_SHIFT) && half_q[0];
        cs_n = !((state_q == ST_LOAD) || (state_q == ST_SHIFT));
        sdo  = 1'b0;
        if (state_q == ST_LOAD) begin
            sdo = pat_sample[DATA_W-1];
        end else if (state_q == ST_SHIFT) begin
            sdo = shreg_q[DATA_W-1];
        end
    end

    assign data_out   = data_out_q;
    assign ch_out     = ch_out_q;
    assign data_valid = dv_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_imi_multi.sv
// Bench for adc_imi_multi: bus monitor with a frame-level pattern model plus directed and random phases.
// Expected LFSR behaviour follows ADC_IMI_LFSR_EN.
module tb_adc_imi_multi;
    import adc_imi_pkg::*;

    localparam int DATA_W  = 12;
    localparam int N_CH    = 4;
    localparam int CLK_DIV = 2;
    localparam int GAP     = 4;
    localparam int CH_W    = 2;
    localparam int LOW_CYC = 1 + 2 * CLK_DIV * DATA_W;
    localparam int PERIOD  = LOW_CYC + GAP;
`ifdef ADC_IMI_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_FIRST = 12'hCE1;
`else
    localparam logic [DATA_W-1:0] LFSR_FIRST = 12'h000;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk_25 = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] fixed_val;
    logic              sck, cs_n, sdo, data_valid, busy;
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   ch_out;
    state_t            dbg_state;

    logic              start2;
    logic [1:0]        mode2;
    logic [3:0]        fixed2;
    logic              sck2, cs_n2, sdo2, dv2, busy2;
    logic [3:0]        d2;
    logic              ch2;
    state_t            dbg_state2;

    always #20 clk_25 = ~clk_25;

    adc_imi_multi #(.DATA_W(DATA_W), .N_CH(N_CH), .CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk_25(clk_25), .reset(reset), .start(start), .mode(mode), .fixed_val(fixed_val),
        .sck(sck), .cs_n(cs_n), .sdo(sdo), .data_out(data_out), .ch_out(ch_out),
        .data_valid(data_valid), .busy(busy), .dbg_state(dbg_state)
    );

    adc_imi_multi #(.DATA_W(4), .N_CH(2), .CLK_DIV(1), .GAP(1)) dut_w (
        .clk_25(clk_25), .reset(reset), .start(start2), .mode(mode2), .fixed_val(fixed2),
        .sck(sck2), .cs_n(cs_n2), .sdo(sdo2), .data_out(d2), .ch_out(ch2),
        .data_valid(dv2), .busy(busy2), .dbg_state(dbg_state2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [CH_W-1:0]   exp_ch_q[$];
    int                m_ch;
    logic [DATA_W-1:0] m_ramp [N_CH];
    logic [15:0]       m_lfsr;

    task automatic model_reset();
        m_ch   = 0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < N_CH; i++) m_ramp[i] = '0;
        exp_q.delete();
        exp_ch_q.delete();
    endtask

    task automatic model_frame(input logic [1:0] md, input logic [DATA_W-1:0] fv);
        logic [DATA_W-1:0] s;
        s = m_ramp[m_ch];
        if (md == 2'd1) begin
            s = fv;
        end else if (md == 2'd3) begin
            s = DATA_W'(m_ch);
        end else if (md == 2'd2) begin
`ifdef ADC_IMI_LFSR_EN
            s = m_lfsr[DATA_W-1:0];
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
`else
            m_ramp[m_ch] = m_ramp[m_ch] + 1;
`endif
        end else begin
            m_ramp[m_ch] = m_ramp[m_ch] + 1;
        end
        exp_q.push_back(s);
        exp_ch_q.push_back(CH_W'(m_ch));
        m_ch = (m_ch + 1) % N_CH;
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    int                cyc = 0;
    int                last_start = 0;
    bit                have_prev = 0;
    bit                busy_run = 0;
    int                low_cnt = 0;
    int                mon_rises = 0;
    logic [DATA_W-1:0] ser = '0;
    logic [DATA_W-1:0] last_ser = '0;
    logic              prev_cs_n = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0;

    always @(negedge clk_25) begin
        cyc++;
        if (reset) begin
            model_reset();
            have_prev = 0; busy_run = 0; mon_rises = 0; low_cnt = 0; ser = '0;
            prev_cs_n = 1'b1; prev_sck = 1'b0; prev_sdo = 1'b0;
        end else begin
            if (!busy) busy_run = 0;
            if (!cs_n && prev_cs_n) begin
                if (have_prev && busy_run) check_eq("period", cyc - last_start, PERIOD);
                have_prev = 1; busy_run = 1; last_start = cyc;
                model_frame(mode, fixed_val);
                low_cnt = 1; mon_rises = 0; ser = '0;
            end else if (!cs_n) begin
                low_cnt++;
            end
            if (sck && !prev_sck) begin
                ser = {ser[DATA_W-2:0], sdo};
                mon_rises++;
            end
            if (!cs_n && !prev_cs_n && (sdo !== prev_sdo))
                check_eq("sdo_edge", {prev_sck, sck}, 2'b10);
            if (cs_n && !prev_cs_n) begin
                check_eq("sck_rises", mon_rises, DATA_W);
                check_eq("cs_low", low_cnt, LOW_CYC);
                check_eq("dv_at_end", data_valid, 1);
                check_eq("sdo_gap", sdo, 0);
                check_eq("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("serial", ser, exp_q[0]);
                    check_eq("data_out", data_out, exp_q[0]);
                    check_eq("ch_out", ch_out, exp_ch_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_ch_q.pop_front());
                end
                last_ser = ser;
            end else if (data_valid) begin
                check_eq("dv_stray", data_valid, 0);
            end
            prev_cs_n = cs_n; prev_sck = sck; prev_sdo = sdo;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic wait_dv(input int budget);
        bit got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk_25);
            #1;
            if (data_valid) got = 1;
        end
        check_eq("dv_wait", got, 1);
    endtask

    task automatic wait_rises(input int k, input int budget);
        bit got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk_25);
            #1;
            if (!cs_n && mon_rises == k) got = 1;
        end
        check_eq("rise_wait", got, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk_25);
            #1;
            if (!busy) got = 1;
        end
        check_eq("idle_wait", got, 1);
    endtask

    initial begin
        repeat (100000) @(posedge clk_25);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int extra;
        bit got;
        reset = 1'b1; start = 1'b0; mode = 2'd0; fixed_val = '0;
        start2 = 1'b0; mode2 = 2'd0; fixed2 = '0;
        repeat (3) @(negedge clk_25);
        #1;
        check_eq("rst_sck", sck, 0);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_sdo", sdo, 0);
        check_eq("rst_dv", data_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_ch", ch_out, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);

        // Ramp: first round all zero, second round starts at 1.
        step(); reset = 1'b0; start = 1'b1; mode = 2'd0;
        for (int k = 0; k < 5; k++) begin
            wait_dv(PERIOD + 8);
            check_eq($sformatf("ramp_ch%0d", k), ch_out, k % N_CH);
            check_eq($sformatf("ramp_val%0d", k), data_out, k / N_CH);
        end

        // Fixed value on channel 1.
        step(); mode = 2'd1; fixed_val = 12'hA5C;
        wait_dv(PERIOD + 8);
        check_eq("fixed_ch", ch_out, 1);
        check_eq("fixed_data", data_out, 12'hA5C);
        check_eq("fixed_bits", last_ser, 12'hA5C);

        // Drop start mid-frame on channel 2.
        step(); mode = 2'd0;
        wait_rises(5, 2 * PERIOD);
        step(); start = 1'b0;
        wait_dv(PERIOD);
        check_eq("stop_ch", ch_out, 2);
        check_eq("stop_data", data_out, 1);
        extra = 0;
        for (int n = 0; n < GAP + 6; n++) begin
            @(negedge clk_25);
            #1;
            if (data_valid) extra++;
        end
        check_eq("stop_dv_once", extra, 0);
        check_eq("stop_busy", busy, 0);
        check_eq("stop_cs_n", cs_n, 1);
        check_eq("stop_state", dbg_state, ST_IDLE);
        step(); start = 1'b1;
        wait_dv(PERIOD + 8);
        check_eq("restart_ch", ch_out, 3);
        check_eq("restart_data", data_out, 1);

        // Asynchronous reset in the middle of a shift.
        wait_rises(3, 2 * PERIOD);
        @(posedge clk_25);
        #5 reset = 1'b1;
        #1;
        check_eq("mid_rst_cs_n", cs_n, 1);
        check_eq("mid_rst_sck", sck, 0);
        check_eq("mid_rst_sdo", sdo, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_dv", data_valid, 0);
        step(); reset = 1'b0;
        wait_dv(PERIOD + 8);
        check_eq("post_rst_ch", ch_out, 0);
        check_eq("post_rst_data", data_out, 0);

        // Mode 2 from a fresh reset.
        step(); reset = 1'b1; start = 1'b0; mode = 2'd2;
        step(); step();
        reset = 1'b0; start = 1'b1;
        wait_dv(PERIOD + 8);
        check_eq("lfsr_first", data_out, LFSR_FIRST);
        for (int k = 0; k < 5; k++) wait_dv(PERIOD + 8);

        // Random mode, value and start changes at arbitrary points.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(5, 70)) @(posedge clk_25);
            #1;
            mode      = 2'($urandom_range(0, 3));
            fixed_val = 12'($urandom);
            start     = ($urandom_range(0, 5) != 0);
        end
        step(); start = 1'b0;
        wait_idle(2 * PERIOD);
        repeat (2) @(negedge clk_25);
        #1;
        check_eq("queue_drained", exp_q.size(), 0);

        // Narrow instance: counters run through all-ones and wrap to zero.
        step(); start2 = 1'b1;
        for (int k = 0; k < 34; k++) begin
            got = 0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk_25);
                #1;
                if (dv2) got = 1;
            end
            check_eq("wrap_wait", got, 1);
            check_eq($sformatf("wrap_ch%0d", k), ch2, k % 2);
            check_eq($sformatf("wrap_val%0d", k), d2, (k / 2) % 16);
        end
        step(); start2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_imi_multi.md
ADC_IMI_MULTI -- requirements
Module: adc_imi_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 12: sample width in bits, legal range 4..16.
REQ-002 SHALL have parameter N_CH, default 4: emulated channel count, legal range 1..16; CH_W = max(1, clog2(N_CH)).
REQ-003 SHALL have parameter CLK_DIV, default 2: sck half-period in clk_25 cycles, minimum 1.
REQ-004 SHALL have parameter GAP, default 4: cs_n-high cycles between frames, minimum 1.
REQ-005 SHALL have port clk_25, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: run enable.
REQ-008 SHALL have port mode, input, 2 bits: pattern select, where 0 = ramp, 1 = fixed, 2 = LFSR, 3 = channel-id.
REQ-009 SHALL have port fixed_val, input, DATA_W bits: mode-1 value.
REQ-010 SHALL have port sck, output, 1 bit: serial clock, idle low.
REQ-011 SHALL have port cs_n, output, 1 bit: frame select, active low.
REQ-012 SHALL have port sdo, output, 1 bit: serial data, MSB first.
REQ-013 SHALL have port data_out, output, DATA_W bits: last frame's sample.
REQ-014 SHALL have port ch_out, output, CH_W bits: last frame's channel.
REQ-015 SHALL have port data_valid, output, 1 bit: one-cycle strobe.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT and GAP.
REQ-018 SHALL go IDLE->LOAD on start=1; LOAD lasts 1 cycle and then goes to SHIFT.
REQ-019 SHALL, in LOAD, latch the sample for the current channel into the shift register, drive cs_n=0 and drive sdo=MSB.
REQ-020 SHALL, in SHIFT, toggle sck every CLK_DIV cycles, producing exactly DATA_W rising edges; sdo changes only on falling edges and is stable on rising edges.
REQ-021 SHALL make SHIFT last 2*CLK_DIV*DATA_W cycles, after which sck=0 and the FSM goes to GAP.
REQ-022 SHALL, on the first GAP cycle, drive cs_n=1 and sdo=0, pulse data_valid for one cycle, and update data_out and ch_out.
REQ-023 SHALL, after GAP cycles, go to LOAD if start=1 or to IDLE if start=0.
REQ-024 SHALL advance the channel index after each frame, wrapping N_CH-1 -> 0.
REQ-025 SHALL, if start falls mid-frame, complete the frame with no truncation; the next start resumes at the next channel.
REQ-026 SHALL make the frame period 1 + 2*CLK_DIV*DATA_W + GAP cycles (53 at default parameters).
REQ-027 SHALL, for mode 0, keep a per-channel DATA_W-bit ramp counter, output it, then increment it after the frame, wrapping all-ones -> 0.
REQ-028 SHALL, for mode 1, use fixed_val as sampled in LOAD.
REQ-029 SHALL, for mode 3, use the channel index zero-extended to DATA_W bits.
REQ-030 SHALL sample mode only in LOAD, so that a mid-frame change affects the next frame only.
REQ-031 SHALL not advance ramp counters in non-ramp modes.

Reset
REQ-032 SHALL, on reset (immediate, including mid-frame), force state=IDLE, sck=0, cs_n=1, sdo=0, data_valid=0, busy=0, data_out=0, ch_out=0, channel index=0, all ramp counters=0 and LFSR=seed.

Configuration
REQ-033 SHALL, with macro ADC_IMI_LFSR_EN defined, make mode 2 output the lower DATA_W bits of a shared 16-bit Galois LFSR (mask 0xB400, seed 0xACE1), advanced once after each mode-2 frame.
REQ-034 SHALL, without ADC_IMI_LFSR_EN, build no LFSR logic and make mode 2 behave exactly as mode 0.

Structure
REQ-035 SHALL place the mode encodings, FSM state type, LFSR seed and LFSR mask in the shared package adc_imi_pkg.
REQ-036 SHALL implement the pattern source (ramp counters, LFSR, mux) as sub-module adc_imi_pattern, and the FSM and serializer in the top module.

Verification
REQ-037 SHALL verify: reset, then start=1, mode=0 -> frames carry ch0..3 = 0x000, the second round carries 0x001; cs_n is low for 49 cycles with 12 sck rises per frame; the period is 53.
REQ-038 SHALL verify: mode=1, fixed_val=0xA5C -> sdo carries 101001011100 on rising edges; data_out=0xA5C.
REQ-039 SHALL verify: 4096 ramp rounds -> ch0 reads 0xFFF, then 0x000.
REQ-040 SHALL verify: start=0 after the 5th sck rise -> the frame completes, data_valid pulses once, then IDLE with cs_n=1 and busy=0; on restart, ch_out equals the previous channel +1.
REQ-041 SHALL verify: reset asserted mid-SHIFT -> the same cycle shows cs_n=1, sck=0 and sdo=0; after release, the first frame is ch0 = 0x000.
REQ-042 SHALL verify: mode=2 with ADC_IMI_LFSR_EN -> first sample 0xCE1; without the macro -> first sample 0x000 (ramp).
